servo_sequencer: RTL and testbench

Sequences the rover's two-servo arm (arm lift + claw) for station pickup and drop-off. Sits between the flag-handling FSM and the servo pins: consumes `servo_EN`/`servo_state`, runs a fixed lower–grip/release–raise routine, generates both servo PWM waveforms, and returns a one-cycle `servo_done` that releases the rover.

---
 rtl/servo_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_servo_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sequencer.sv
// Two-servo arm sequencer: lower, grip/release, raise, then handshake back to the requester.
// Generates both servo PWM waveforms from one free-running frame counter.
module servo_sequencer #(
    parameter int FRAME_CYC    = 2_000_000,
    parameter int ARM_UP       = 200_000,
    parameter int ARM_DOWN     = 100_000,
    parameter int CLAW_OPEN    = 100_000,
    parameter int CLAW_CLOSED  = 200_000,
    parameter int DWELL_FRAMES = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       servo_EN,
    input  logic       servo_state,
    output logic       arm_pwm,
    output logic       claw_pwm,
    output logic       servo_done,
    output logic       busy,
    output logic [2:0] step
);

    localparam int FC_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int PW_W = $clog2(FRAME_CYC + 1);
    localparam int DW_W = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;

    localparam logic [FC_W-1:0] FRAME_LAST  = FC_W'(FRAME_CYC - 1);
    localparam logic [PW_W-1:0] ARM_UP_W    = PW_W'(ARM_UP);
    localparam logic [PW_W-1:0] ARM_DOWN_W  = PW_W'(ARM_DOWN);
    localparam logic [PW_W-1:0] CLAW_OPEN_W = PW_W'(CLAW_OPEN);
    localparam logic [PW_W-1:0] CLAW_CLS_W  = PW_W'(CLAW_CLOSED);
    localparam logic [DW_W-1:0] DWELL_LAST  = DW_W'(DWELL_FRAMES - 1);

    // frame_cnt is 0 in reset, so the pins start high whenever the reset width is nonzero
    localparam logic ARM_PWM_RST  = (ARM_UP > 0) ? 1'b1 : 1'b0;
    localparam logic CLAW_PWM_RST = (CLAW_OPEN > 0) ? 1'b1 : 1'b0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOWER = 3'd1;
    localparam logic [2:0] ST_GRIP  = 3'd2;
    localparam logic [2:0] ST_RAISE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

    logic [2:0]      state_r;
    logic [2:0]      state_s;
    logic            op_r;
    logic            op_s;
    logic [DW_W-1:0] dwell_r;
    logic [DW_W-1:0] dwell_s;
    logic [FC_W-1:0] frame_cnt_r;
    logic [FC_W-1:0] frame_cnt_s;
    logic            frame_end_s;
    logic [PW_W-1:0] arm_w_r;
    logic [PW_W-1:0] arm_w_s;
    logic [PW_W-1:0] claw_w_r;
    logic [PW_W-1:0] claw_w_s;
    logic [PW_W-1:0] arm_tgt_s;
    logic [PW_W-1:0] claw_tgt_s;
    logic [PW_W-1:0] fc_ext_s;
    logic            arm_pwm_r;
    logic            claw_pwm_r;
    logic            done_r;
    logic            busy_r;

    // Free-running frame counter and its wrap point
    always_comb begin
        frame_end_s = (frame_cnt_r == FRAME_LAST);
        if (frame_end_s) begin
            frame_cnt_s = {FC_W{1'b0}};
        end else begin
            frame_cnt_s = frame_cnt_r + FC_W'(1);
        end
        fc_ext_s = PW_W'(frame_cnt_s);
    end

    // Routine sequencing; dwell counts frame boundaries and clears on every state change
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        dwell_s = {DW_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (servo_EN) begin
                    state_s = ST_LOWER;
                    op_s    = servo_state;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOWER, ST_GRIP, ST_RAISE: begin
                if (frame_end_s) begin
                    if (dwell_r == DWELL_LAST) begin
                        state_s = state_r + 3'd1;
                        dwell_s = {DW_W{1'b0}};
                    end else begin
                        dwell_s = dwell_r + DW_W'(1);
                    end
                end else begin
                    dwell_s = dwell_r;
                end
            end
            ST_DONE: begin
                state_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (!servo_EN) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Width targets follow the state being entered, so a boundary transition takes effect in the next frame
    always_comb begin
        arm_tgt_s  = arm_w_r;
        claw_tgt_s = claw_w_r;
        case (state_s)
            ST_LOWER: begin
                arm_tgt_s = ARM_DOWN_W;
            end
            ST_GRIP: begin
                arm_tgt_s  = ARM_DOWN_W;
                claw_tgt_s = op_s ? CLAW_OPEN_W : CLAW_CLS_W;
            end
            ST_RAISE: begin
                arm_tgt_s = ARM_UP_W;
            end
            default: begin
                arm_tgt_s  = arm_w_r;
                claw_tgt_s = claw_w_r;
            end
        endcase
        if (frame_end_s) begin
            arm_w_s  = arm_tgt_s;
            claw_w_s = claw_tgt_s;
        end else begin
            arm_w_s  = arm_w_r;
            claw_w_s = claw_w_r;
        end
    end

    // State, widths and registered outputs; pins are registered from next-cycle compare values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 1'b0;
            dwell_r     <= {DW_W{1'b0}};
            frame_cnt_r <= {FC_W{1'b0}};
            arm_w_r     <= ARM_UP_W;
            claw_w_r    <= CLAW_OPEN_W;
            arm_pwm_r   <= ARM_PWM_RST;
            claw_pwm_r  <= CLAW_PWM_RST;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            dwell_r     <= dwell_s;
            frame_cnt_r <= frame_cnt_s;
            arm_w_r     <= arm_w_s;
            claw_w_r    <= claw_w_s;
            arm_pwm_r   <= (fc_ext_s < arm_w_s);
            claw_pwm_r  <= (fc_ext_s < claw_w_s);
            done_r      <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign arm_pwm    = arm_pwm_r;
    assign claw_pwm   = claw_pwm_r;
    assign servo_done = done_r;
    assign busy       = busy_r;
    assign step       = state_r;

endmodule

// File: tb/tb_servo_sequencer.sv
// Randomized bench for servo_sequencer against a frame/step-level reference model.
module tb_servo_sequencer;

    localparam int FC = 100;
    localparam int AU = 20;
    localparam int AD = 10;
    localparam int CO = 10;
    localparam int CC = 20;
    localparam int DF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       servo_EN = 1'b0;
    logic       servo_state = 1'b0;
    logic       arm_pwm;
    logic       claw_pwm;
    logic       servo_done;
    logic       busy;
    logic [2:0] step;

    servo_sequencer #(
        .FRAME_CYC(FC), .ARM_UP(AU), .ARM_DOWN(AD),
        .CLAW_OPEN(CO), .CLAW_CLOSED(CC), .DWELL_FRAMES(DF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .servo_EN(servo_EN), .servo_state(servo_state),
        .arm_pwm(arm_pwm), .claw_pwm(claw_pwm), .servo_done(servo_done),
        .busy(busy), .step(step)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: position in frame, routine step, latched op, frames seen in step, active widths
    int m_t, m_ph, m_op, m_frames, m_arm, m_claw;
    int obs_done;
    int arm_hi, claw_hi, fr_arm, fr_claw;
    bit fr_valid;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_ph = 0; m_op = 0; m_frames = 0; m_arm = AU; m_claw = CO;
        fr_valid = 1'b0;
    endtask

    // One clock of routine rules: steps 1..3 each last DF frame boundaries; widths change only at frame start
    task automatic model_edge();
        bit boundary;
        int nxt;
        boundary = (m_t == FC - 1);
        nxt = m_ph;
        if (m_ph == 0 && servo_EN) begin
            nxt = 1;
            m_op = servo_state;
        end else if (m_ph >= 1 && m_ph <= 3 && boundary) begin
            m_frames++;
            if (m_frames == DF) begin
                nxt = m_ph + 1;
                m_frames = 0;
            end
        end else if (m_ph == 4) begin
            nxt = 5;
        end else if (m_ph == 5 && !servo_EN) begin
            nxt = 0;
        end
        if (boundary) begin
            if (nxt == 1 || nxt == 2) m_arm = AD;
            if (nxt == 3) m_arm = AU;
            if (nxt == 2) m_claw = (m_op != 0) ? CO : CC;
        end
        m_ph = nxt;
        m_t = boundary ? 0 : m_t + 1;
    endtask

    task automatic compare_all();
        check_val("step", step, m_ph);
        check_val("busy", busy, (m_ph != 0));
        check_val("servo_done", servo_done, (m_ph == 4));
        check_val("arm_pwm", arm_pwm, (m_t < m_arm));
        check_val("claw_pwm", claw_pwm, (m_t < m_claw));
        if (servo_done === 1'b1) obs_done++;
        if (m_t == 0) begin
            arm_hi = 0; claw_hi = 0; fr_arm = m_arm; fr_claw = m_claw; fr_valid = 1'b1;
        end
        if (arm_pwm === 1'b1) arm_hi++;
        if (claw_pwm === 1'b1) claw_hi++;
        if (m_t == FC - 1 && fr_valid) begin
            check_val("arm_pulse_len", arm_hi, fr_arm);
            check_val("claw_pulse_len", claw_hi, fr_claw);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin
            tick();
            n++;
        end
        if (m_ph != ph) check_val("wait_timeout", m_ph, ph);
    endtask

    task automatic do_reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_step", step, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", servo_done, 0);
        check_val("rst_arm_pwm", arm_pwm, 1);
        check_val("rst_claw_pwm", claw_pwm, 1);
        model_reset();
        servo_EN = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    task automatic full_routine(input bit op);
        int d0;
        d0 = obs_done;
        servo_state = op;
        servo_EN = 1'b1;
        wait_phase(5, 1000);
        run($urandom_range(1, 20));
        servo_EN = 1'b0;
        wait_phase(0, 10);
        check_val(op ? "dropoff_done_cnt" : "pickup_done_cnt", obs_done - d0, 1);
    endtask

    initial begin
        int d0;
        int n;
        model_reset();
        obs_done = 0;
        repeat (3) @(negedge clk);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        run($urandom_range(30, 70));

        do_reset_pulse();
        run(2 * FC);

        full_routine(1'b0);
        full_routine(1'b1);

        // EN dropped in LOWER while servo_state wanders: latched op must rule
        d0 = obs_done;
        servo_state = 1'($urandom_range(0, 1));
        servo_EN = 1'b1;
        wait_phase(1, 5);
        run($urandom_range(3, 20));
        servo_EN = 1'b0;
        n = 0;
        while (m_ph != 5 && n < 1000) begin
            servo_state = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tick();
        check_val("hold_exit_step", step, 0);
        check_val("en_drop_done_cnt", obs_done - d0, 1);

        // Requester keeps EN high long after DONE
        d0 = obs_done;
        servo_state = 1'b0;
        servo_EN = 1'b1;
        wait_phase(5, 1000);
        run(500);
        check_val("held_step", step, 5);
        check_val("held_done_cnt", obs_done - d0, 1);
        servo_EN = 1'b0;
        run(2);
        servo_EN = 1'b1;
        tick();
        check_val("restart_step", step, 1);
        wait_phase(5, 1000);
        servo_EN = 1'b0;
        wait_phase(0, 10);

        // Start timed so the state changes at frame_cnt=5
        n = 0;
        while (m_t != 4 && n < 200) begin
            tick();
            n++;
        end
        check_val("align_frame", m_t, 4);
        full_routine(1'b1);

        // Reset mid-routine: no servo_done
        d0 = obs_done;
        servo_EN = 1'b1;
        servo_state = 1'b0;
        run($urandom_range(50, 400));
        do_reset_pulse();
        run(FC + 10);
        check_val("rst_mid_done_cnt", obs_done - d0, 0);

        for (int i = 0; i < 4; i++) begin
            run($urandom_range(0, 150));
            full_routine(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
